// File: rtl/ts_pkg.sv
// ts_pkg: shared definitions for the event timestamper.
//   TS_WIDTH_DEFAULT : default width of the count bus / captured words
//   TS_DEPTH_DEFAULT : default FIFO depth
//   ts_clog2()       : ceiling log2, used to size FIFO pointers
package ts_pkg;

  localparam int TS_WIDTH_DEFAULT = 32;
  localparam int TS_DEPTH_DEFAULT = 8;

  function automatic int ts_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ts_sync_fifo.sv
// ts_sync_fifo: single-clock FIFO for captured timestamp words.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push, din   : write request and data; accepted when not full, or when
//                 full and a pop happens in the same cycle
//   pop, dout   : read request (ignored while empty) and head-of-FIFO word;
//                 dout reads 0 while empty, and shows a word written into an
//                 empty FIFO on the following cycle
//   full, empty : occupancy flags
//   fill        : occupancy, AW+1 bits
module ts_sync_fifo
  import ts_pkg::*;
#(
  parameter int WIDTH = TS_WIDTH_DEFAULT,
  parameter int DEPTH = TS_DEPTH_DEFAULT,
  localparam int AW = ts_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      fill
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_cnt;
  logic [AW:0]      rd_cnt;
  logic             do_push;
  logic             do_pop;

  // Counters carry one extra bit so full and empty are distinguishable;
  // the low AW bits index storage and wrap naturally.
  assign fill  = wr_cnt - rd_cnt;
  assign empty = (fill == '0);
  assign full  = (fill == FULL_LVL);

  assign do_pop  = pop & ~empty;
  // A pop frees the head slot in the same cycle, so a full FIFO still
  // accepts a push that coincides with a pop.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + 1'b1;
      if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_cnt[AW-1:0]] <= din;
  end

  // Storage is not reset; gating on empty keeps the output at 0 after reset.
  assign dout = empty ? '0 : mem[rd_cnt[AW-1:0]];

endmodule

// File: rtl/event_timestamper.sv
// event_timestamper: latches the free-running count on each rising edge of an
// asynchronous event input and queues the results for a valid/ready reader.
// Optional feature macro: TS_DELTA_EN
//   undefined : each armed event queues the raw captured count
//   defined   : each armed event queues (cap - previous cap) mod 2^WIDTH; the
//               first armed event after reset only primes the reference
// Ports:
//   clk, reset : clock shared with the counter, synchronous active-high reset
//   count      : free-running count bus
//   evt_in     : asynchronous event input (hold high >=2 and low >=2 cycles)
//   arm        : 1 = captures enabled, 0 = edges ignored
//   ts_data    : head-of-FIFO word (0 while empty)
//   ts_valid   : FIFO not empty
//   ts_ready   : consumer accepts the head word when ts_valid is high
//   ovf        : sticky, one or more events dropped on a full FIFO
//   ovf_clr    : clears ovf (a coincident drop wins)
//   fill       : FIFO occupancy
module event_timestamper
  import ts_pkg::*;
#(
  parameter int WIDTH = TS_WIDTH_DEFAULT,
  parameter int DEPTH = TS_DEPTH_DEFAULT,
  localparam int AW = ts_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             evt_in,
  input  logic             arm,
  output logic [WIDTH-1:0] ts_data,
  output logic             ts_valid,
  input  logic             ts_ready,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [AW:0]      fill
);

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             cap_evt;
  logic             push;
  logic [WIDTH-1:0] word;
  logic             full;
  logic             empty;
  logic             drop;

  // ---- synchronizer (s1, s2) and edge-detect delay (s3) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= evt_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise    = s2 & ~s3;
  assign cap_evt = rise & arm;

  // ---- capture / word formation ----
`ifdef TS_DELTA_EN
  logic [WIDTH-1:0] last_cap;
  logic             primed;

  function automatic logic [WIDTH-1:0] mod_delta(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] prev);
    // Unsigned subtraction wraps modulo 2^WIDTH, which absorbs counter wrap.
    return cur - prev;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      primed <= 1'b0;
    end else if (cap_evt) begin
      primed <= 1'b1;
    end
  end

  // Reference moves on every armed event, even when the resulting word is
  // dropped, so each delta always spans two adjacent detected events.
  always_ff @(posedge clk) begin
    if (cap_evt) last_cap <= count;
  end

  assign push = cap_evt & primed;
  assign word = mod_delta(count, last_cap);
`else
  assign push = cap_evt;
  assign word = count;
`endif

  // ---- FIFO ----
  ts_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (word),
    .pop   (ts_ready),
    .dout  (ts_data),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  assign ts_valid = ~empty;

  // ---- overflow flag ----
  assign drop = push & full & ~ts_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_event_timestamper.sv
module tb_event_timestamper;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] count = '0;
  logic        evt = 1'b0;
  logic        arm = 1'b0;
  logic [31:0] ts_data;
  logic        ts_valid;
  logic        ready = 1'b0;
  logic        ovf;
  logic        ovf_clr = 1'b0;
  logic [3:0]  fill;

  logic [7:0]  count8 = '0;
  logic        evt8 = 1'b0;
  logic [7:0]  ts_data8;
  logic        ts_valid8;
  logic        ready8 = 1'b0;
  logic        ovf8;
  logic        ovf_clr8 = 1'b0;
  logic [2:0]  fill8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  event_timestamper #(.WIDTH(32), .DEPTH(8)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .count    (count),
    .evt_in   (evt),
    .arm      (arm),
    .ts_data  (ts_data),
    .ts_valid (ts_valid),
    .ts_ready (ready),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .fill     (fill)
  );

  event_timestamper #(.WIDTH(8), .DEPTH(4)) u_w8 (
    .clk      (clk),
    .reset    (reset),
    .count    (count8),
    .evt_in   (evt8),
    .arm      (arm),
    .ts_data  (ts_data8),
    .ts_valid (ts_valid8),
    .ts_ready (ready8),
    .ovf      (ovf8),
    .ovf_clr  (ovf_clr8),
    .fill     (fill8)
  );

  typedef struct {
    logic [31:0] cnt;
    bit          pushes;
    logic [31:0] word;
  } vec_t;

  vec_t        tbl [3];
  logic [31:0] exp_q [8];
  int          exp_fill;
  int          n_ok;
  logic [31:0] v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture happens on the third edge after evt goes high; count is held
  // steady across the rise so the captured value is exactly v.
  task automatic pulse_rise(input bit sel, input logic [31:0] val, input bit clr_cap, input bit pop_cap);
    if (sel) begin evt8 = 1'b1; count8 = val[7:0]; end
    else     begin evt  = 1'b1; count  = val;      end
    tick();
    tick();
    ovf_clr = clr_cap;
    ready   = pop_cap;
    tick();
    ovf_clr = 1'b0;
    ready   = 1'b0;
  endtask

  task automatic pulse_fall(input bit sel);
    if (sel) evt8 = 1'b0;
    else     evt  = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic pulse(input bit sel, input logic [31:0] val);
    pulse_rise(sel, val, 1'b0, 1'b0);
    pulse_fall(sel);
  endtask

  task automatic pop_one();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    tick();
    check("rst_fill", 32'(fill), 0);
    check("rst_valid", 32'(ts_valid), 0);
    check("rst_data", ts_data, 0);
    check("rst_ovf", 32'(ovf), 0);
    reset = 1'b0;
    arm = 1'b1;

    // single capture at count 100
    pulse_rise(1'b0, 32'd100, 1'b0, 1'b0);
`ifdef TS_DELTA_EN
    check("first_evt_valid", 32'(ts_valid), 0);
    check("first_evt_fill", 32'(fill), 0);
    pulse_fall(1'b0);
`else
    check("cap100_valid", 32'(ts_valid), 1);
    check("cap100_data", ts_data, 100);
    check("cap100_fill", 32'(fill), 1);
    pulse_fall(1'b0);
    pop_one();
    check("pop100_valid", 32'(ts_valid), 0);
    check("pop100_fill", 32'(fill), 0);
`endif

    // table-driven event sequence
    do_reset();
`ifdef TS_DELTA_EN
    tbl[0] = '{32'd1000, 1'b0, 32'd0};
    tbl[1] = '{32'd1250, 1'b1, 32'd250};
    tbl[2] = '{32'd1600, 1'b1, 32'd350};
`else
    tbl[0] = '{32'd1000, 1'b1, 32'd1000};
    tbl[1] = '{32'd1250, 1'b1, 32'd1250};
    tbl[2] = '{32'd1600, 1'b1, 32'd1600};
`endif
    exp_fill = 0;
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, tbl[i].cnt);
      if (tbl[i].pushes) exp_fill++;
      check("tbl_fill", 32'(fill), 32'(exp_fill));
    end
    for (int i = 0; i < 3; i++) begin
      if (tbl[i].pushes) begin
        check("tbl_valid", 32'(ts_valid), 1);
        check("tbl_word", ts_data, tbl[i].word);
        pop_one();
      end
    end
    check("tbl_drained", 32'(ts_valid), 0);
    check("tbl_ovf", 32'(ovf), 0);

    // 8-bit counter wrap: 250 then 4
    pulse(1'b1, 32'd250);
    pulse(1'b1, 32'd4);
`ifdef TS_DELTA_EN
    check("wrap_fill", 32'(fill8), 1);
    check("wrap_delta", 32'(ts_data8), 10);
`else
    check("wrap_fill", 32'(fill8), 2);
    check("wrap_head", 32'(ts_data8), 250);
`endif

    // overflow: 10 events with no reader
    do_reset();
`ifdef TS_DELTA_EN
    n_ok = 8;
`else
    n_ok = 7;
`endif
    for (int i = 0; i < 10; i++) begin
      v = 32'(2000 + 5 * i * (i + 1));
      pulse(1'b0, v);
      if (i == n_ok) begin
        check("prefull_ovf", 32'(ovf), 0);
        check("prefull_fill", 32'(fill), 8);
      end
    end
    check("ovf_fill", 32'(fill), 8);
    check("ovf_set", 32'(ovf), 1);
`ifdef TS_DELTA_EN
    check("ovf_head", ts_data, 10);
`else
    check("ovf_head", ts_data, 2000);
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 0);
    pulse_rise(1'b0, 32'd3000, 1'b1, 1'b0);
    check("ovf_set_wins", 32'(ovf), 1);
    check("ovf_drop_fill", 32'(fill), 8);
    pulse_fall(1'b0);

    // push with simultaneous pop while full
    pulse_rise(1'b0, 32'd3100, 1'b0, 1'b1);
    check("fullpop_fill", 32'(fill), 8);
    pulse_fall(1'b0);
    for (int k = 0; k < 7; k++) begin
`ifdef TS_DELTA_EN
      exp_q[k] = 32'(10 * (k + 2));
`else
      exp_q[k] = 32'(2000 + 5 * (k + 1) * (k + 2));
`endif
    end
`ifdef TS_DELTA_EN
    exp_q[7] = 32'd100;
`else
    exp_q[7] = 32'd3100;
`endif
    for (int k = 0; k < 8; k++) begin
      check("order_word", ts_data, exp_q[k]);
      pop_one();
    end
    check("order_empty", 32'(ts_valid), 0);

    // disarmed event
    arm = 1'b0;
    pulse(1'b0, 32'd4000);
    check("disarm_fill", 32'(fill), 0);
    arm = 1'b1;

    // one-cycle glitch: at most one capture, no X
    evt = 1'b1;
    count = 32'd5000;
    tick();
    evt = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("glitch_noX", 32'($isunknown(ts_data) | $isunknown(fill)), 0);
    check("glitch_le1", 32'(fill <= 4'd1), 1);
    if (ts_valid) pop_one();

    // reset with 5 entries buffered
    do_reset();
`ifdef TS_DELTA_EN
    for (int k = 0; k < 6; k++) pulse(1'b0, 32'(6000 + 7 * k));
`else
    for (int k = 0; k < 5; k++) pulse(1'b0, 32'(6000 + 7 * k));
`endif
    check("pre_rst_fill", 32'(fill), 5);
    reset = 1'b1;
    tick();
    check("midrst_fill", 32'(fill), 0);
    check("midrst_valid", 32'(ts_valid), 0);
    check("midrst_data", ts_data, 0);
    reset = 1'b0;
    pulse(1'b0, 32'd7000);
`ifdef TS_DELTA_EN
    check("post_rst_noentry", 32'(fill), 0);
`else
    check("post_rst_fill", 32'(fill), 1);
    check("post_rst_data", ts_data, 7000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_timestamper.md
Name: event_timestamper

Overview:
- Downstream consumer of the free-running `counter1` count bus (`out`, WIDTH bits, +1 per `clk`).
- Detects rising edges on an asynchronous external event input and latches the counter value at each edge.
- Buffers captures in a small FIFO and presents them on a valid/ready interface to the readout/host stage.
- Basis for period and frequency measurement on the Spartan-6 counter board.

Parameters:
- WIDTH, 32, width of the count bus and of each captured word; must match `counter1` WIDTH.
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- AW, $clog2(DEPTH), localparam, FIFO pointer width.

Ports:
- clk  in  1  system clock; same clock as `counter1`.
- reset  in  1  synchronous, active-high reset.
- count  in  WIDTH  free-running count from `counter1`.
- evt_in  in  1  asynchronous event input.
- arm  in  1  1 = captures enabled; 0 = edges ignored.
- ts_data  out  WIDTH  head-of-FIFO word.
- ts_valid  out  1  FIFO not empty.
- ts_ready  in  1  consumer accepts the word when ts_valid & ts_ready.
- ovf  out  1  sticky flag: one or more events dropped.
- ovf_clr  in  1  clears ovf.
- fill  out  AW+1  current FIFO occupancy.

Behaviour:
- **Clocking and reset:** one clock domain (`clk`). `reset` is synchronous and active-high. In the reset cycle: FIFO emptied, ts_valid=0, ts_data=0, fill=0, ovf=0, synchronizer and edge registers=0, primed=0. Reset mid-operation discards all buffered entries; no partial pop is visible.
- **Synchronizer and edge detect:**
  - evt_in passes through a 2-FF synchronizer (s1, s2), then a delay register s3.
  - rise = s2 & ~s3.
  - evt_in must stay high ≥2 cycles and low ≥2 cycles; shorter pulses may be missed.
- **Capture:**
  - On an edge with rise=1 and arm=1, cap = count as sampled at that edge.
  - Offset is fixed at 2–3 cycles after the evt_in transition and is not compensated.
  - rise with arm=0 is ignored entirely: no push, no state update.
- **Word formation:** defined by the optional feature (raw timestamp or delta).
- **FIFO push:**
  - A push occurs on the capture edge if a word is produced.
  - The word is visible at ts_data/ts_valid on the following cycle (1-cycle latency when the FIFO was empty).
- **Handshake:**
  - Pop on ts_valid & ts_ready.
  - ts_data is held stable while ts_valid=1 and ts_ready=0.
  - ts_ready while empty has no effect.
- **Full:**
  - Push while fill==DEPTH with no simultaneous pop: word dropped, ovf<=1.
  - Push and pop in the same cycle while full: push accepted, fill unchanged.
  - Simultaneous push and pop at any fill: fill unchanged.
- **Overflow clear:** ovf_clr clears ovf. If ovf_clr coincides with a new drop, ovf=1 (set wins).
- **Arithmetic:** all arithmetic is modulo 2^WIDTH; counter wrap-around needs no special case.
- **Pointers:** AW-bit pointers wrap naturally; fill = wr_count - rd_count, AW+1 bits wide.

Optional Feature:
- Macro: TS_DELTA_EN.
- **Defined:**
  - Word = cap - last_cap (mod 2^WIDTH), i.e. the event period in clocks.
  - The first armed event after reset only loads last_cap and sets primed=1; no push.
  - last_cap updates on every armed event, including dropped ones, so deltas always span adjacent detected events.
  - Deasserting arm does not clear primed.
- **Undefined:** word = cap (raw timestamp). Every armed event pushes. No last_cap/primed logic.

Decomposition:
- Shared package/include (ts_pkg) holds:
  - TS_WIDTH_DEFAULT = 32;
  - TS_DEPTH_DEFAULT = 8;
  - the clog2 function used for AW.
- Sub-module: ts_sync_fifo.
  - Parameterised WIDTH and DEPTH.
  - Signals: push/din, pop/dout, full, empty, fill.
  - Registered storage; dout valid the cycle after write-into-empty.
- Top level holds: synchronizer, edge detect, capture/delta logic, ovf.

Test Plan:
1. Raw mode (macro undefined): arm=1; evt_in pulse with count at capture = 100 → ts_valid rises next cycle, ts_data=100, fill=1; ts_ready=1 one cycle → ts_valid=0, fill=0.
2. Delta mode: events captured at count 1000, 1250, 1600 → exactly 2 entries, 250 then 350; ovf=0.
3. Wrap: delta mode with WIDTH=8; captures at 250 then 4 → ts_data=10.
4. Overflow: ts_ready=0, DEPTH=8, 10 armed events → fill=8, ovf=1, head entry is the first event. Pulse ovf_clr → ovf=0. Drop coincident with ovf_clr → ovf=1.
5. Full with simultaneous pop: fill=8 and ts_ready=1 on the push edge → push accepted, fill stays 8, sequence order preserved.
6. Arm/reset/glitch:
   - arm=0 event → no entry.
   - 1-cycle evt_in pulse → no guarantee; bench checks no X and no double capture.
   - reset asserted with fill=5 → next cycle fill=0, ts_valid=0, ts_data=0.
   - Delta mode: first event after reset produces no entry.
